wb_sched: RTL and testbench
===========================

# wb_sched

Writeback scheduler for the 32×64 integer register file. Several producers compete for the file's single write port: the ALU, the load unit and the system/ecall unit. This block arbitrates between them and drives the file's write port from a registered stage. It also keeps a per-register busy scoreboard so issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = system)
- XLEN, 64, data width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a writeback pending
- req_addr  in  NUM_REQ×5  destination register of requester i
- req_data  in  NUM_REQ×XLEN  writeback data of requester i
- req_ready  out  NUM_REQ  grant to requester i; combinational; at most one bit set
- rsv_valid  in  1  issue reserves a destination this cycle
- rsv_addr  in  5  destination register being reserved
- chk_addr1, chk_addr2  in  5 each  source registers of the instruction at issue
- chk_dst  in  5  destination register of the instruction at issue
- chk_busy  out  1  combinational; high if any of the three checked registers is busy
- wb_en  out  1  register-file write enable (registered)
- wb_addr  out  5  register-file write address (registered)
- wb_data  out  XLEN  register-file write data (registered)
- sb_busy  out  32  scoreboard vector; bit 0 is always 0
- sb_err  out  1  sticky error flag

## Operation
- **Arbitration**
  - Each cycle, grant at most one requester with req_valid = 1.
  - req_ready[i] = 1 only for the winner, independent of the winner's own req_valid path.
  - A transfer occurs when req_valid[i] & req_ready[i].
- **Write stage**
  - On a transfer, the next edge loads wb_addr/wb_data and sets wb_en = 1 for exactly one cycle.
  - With no transfer, wb_en = 0 and wb_addr/wb_data hold their values.
  - A transfer with req_addr = 0 is accepted (ready asserted) but produces wb_en = 0.
- **Scoreboard**
  - sb_busy[a] is set on the edge where rsv_valid = 1 and rsv_addr = a ≠ 0.
  - sb_busy[a] is cleared on the edge ending a cycle where wb_en = 1 and wb_addr = a.
  - Same edge sets and clears the same a: set wins, because a new outstanding write exists.
  - Reserving a register that is already busy without a same-edge clear sets sb_err; the busy bit stays set.
  - sb_err clears only on reset.
  - chk_busy = sb_busy[chk_addr1] | sb_busy[chk_addr2] | sb_busy[chk_dst]. Register 0 is never busy.
- A requester whose req_addr is not busy is still accepted. No check is made on the write side.

## Timing
- Reset values:
  - wb_en = 0, wb_addr = 0, wb_data = 0
  - sb_busy = 0, sb_err = 0
  - round-robin pointer = NUM_REQ−1, so requester 0 has first priority
- Reset asserted mid-operation clears all state immediately. Any in-flight registered write is dropped (wb_en falls asynchronously).
- Latency:
  - transfer in cycle N → wb_en = 1 in cycle N+1
  - register file written at the end of N+1
  - sb_busy clear visible in N+2
  - a reader issuing in N+2 sees chk_busy = 0 and reads the new value
- No bypass: a reader in cycle N+1 still sees busy.
- Throughput: one writeback per cycle sustained.
- req_valid may drop without a grant; there is no lock-in.

## Configuration
- WB_SCHED_RR_EN defined:
  - Round-robin arbitration.
  - Priority starts at (last grantee + 1) mod NUM_REQ.
  - The pointer advances only on a transfer.
- WB_SCHED_RR_EN undefined:
  - Fixed priority; the lowest index wins.
  - No pointer state; the reset-value rule for the pointer does not apply.

## Structure
- Package wb_pkg:
  - REG_ADDR_W = 5, NUM_REGS = 32, XLEN default
  - requester index enum: REQ_ALU = 0, REQ_LOAD = 1, REQ_SYS = 2
- One sub-module, wb_rr_arbiter: a parameterised NUM_REQ one-hot grant with an internal pointer, or fixed priority when WB_SCHED_RR_EN is undefined.
- The scoreboard and write stage live in wb_sched itself.

## Test plan
- Reset, then requester 1 writes x5 = 0xDEAD_BEEF → req_ready = 3'b010 in the same cycle; wb_en = 1, wb_addr = 5, wb_data = 0xDEAD_BEEF exactly one cycle later, then wb_en = 0.
- All three requesters are valid continuously for 6 cycles with RR enabled → grants 0,1,2,0,1,2. With RR disabled → grant 0 every cycle, and req_ready[1], req_ready[2] stay 0.
- Reserve x7, then requester 0 writes x7:
  - chk_addr1 = 7 → chk_busy = 1 through the wb_en cycle
  - chk_busy = 0 the cycle after
  - sb_busy[7] follows the same sequence
- rsv x9 on the same edge as wb_en with wb_addr = 9 → sb_busy[9] remains 1 and sb_err stays 0. Reserve x9 again while busy → sb_err = 1, sticky.
- Requester 2 writes x0 → req_ready[2] = 1, wb_en stays 0. Reserving x0 → sb_busy[0] stays 0.
- Assert reset_n = 0 mid-cycle with wb_en = 1 and sb_busy = 0x0000_0080 → wb_en, sb_busy and sb_err drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback scheduler.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 64;

    // Requester slots on the writeback port
    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_SYS  = 2'd2
    } req_idx_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant arbiter for the writeback port.
// WB_SCHED_RR_EN defined: round-robin, search starts one past the last
// grantee, and the pointer only moves when a grant (transfer) happens.
// WB_SCHED_RR_EN undefined: fixed priority, lowest index wins, stateless.
module wb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
`ifdef WB_SCHED_RR_EN
    input  logic               clk,
    input  logic               reset_n,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

`ifdef WB_SCHED_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic             found_c;
    int               idx_c;

    // Rotating search from last grantee + 1; first valid requester wins
    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        found_c  = 1'b0;
        idx_c    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx_c = int'(ptr_reg) + off;
            if (idx_c >= NUM_REQ) begin
                idx_c = idx_c - NUM_REQ;
            end
            if (!found_c && req[idx_c]) begin
                grant[idx_c] = 1'b1;
                ptr_next     = PTR_W'(idx_c);
                found_c      = 1'b1;
            end
        end
    end

    // Pointer remembers the last grantee; reset value gives requester 0 first turn
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    // Fixed priority: isolate the lowest set request bit
    always_comb begin
        grant = req & (~req + NUM_REQ'(1));
    end
`endif

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates ALU/load/system writebacks onto the single
// register-file write port through a registered write stage, and keeps a
// per-register busy scoreboard for RAW/WAW stalls at issue.
// Optional feature macro: WB_SCHED_RR_EN (round-robin instead of fixed priority).
module wb_sched #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = wb_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    rsv_valid,
    input  logic [4:0]              rsv_addr,
    input  logic [4:0]              chk_addr1,
    input  logic [4:0]              chk_addr2,
    input  logic [4:0]              chk_dst,
    output logic                    chk_busy,
    output logic                    wb_en,
    output logic [4:0]              wb_addr,
    output logic [XLEN-1:0]         wb_data,
    output logic [31:0]             sb_busy,
    output logic                    sb_err
);
    import wb_pkg::*;

    logic [NUM_REQ-1:0]    grant;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    logic                  wb_en_reg;
    logic [REG_ADDR_W-1:0] wb_addr_reg;
    logic [XLEN-1:0]       wb_data_reg;

    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;
    logic                  err_reg;
    logic                  err_next;

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
`ifdef WB_SCHED_RR_EN
        .clk     (clk),
        .reset_n (reset_n),
`endif
        .req     (req_valid),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    // Route the winner's address and data toward the write stage
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Registered write stage: one-cycle write pulse per transfer; x0 writes are swallowed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_en_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            wb_en_reg <= transfer && (sel_addr != '0);
            if (transfer) begin
                wb_addr_reg <= sel_addr;
                wb_data_reg <= sel_data;
            end
        end
    end

    // Per-register set/clear; x0 is hardwired not-busy
    assign set_vec[0]   = 1'b0;
    assign clr_vec[0]   = 1'b0;
    assign busy_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            assign set_vec[gi]   = rsv_valid && (rsv_addr == REG_ADDR_W'(gi));
            assign clr_vec[gi]   = wb_en_reg && (wb_addr_reg == REG_ADDR_W'(gi));
            // A same-edge reservation wins: it represents a newer outstanding write
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Double reservation of a still-busy register (not being retired) is sticky
    assign err_next = err_reg | (|(set_vec & busy_reg & ~clr_vec));

    // Scoreboard and error flag state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            err_reg  <= err_next;
        end
    end

    // Issue-side hazard check, no bypass from the write stage
    assign chk_busy = busy_reg[chk_addr1] | busy_reg[chk_addr2] | busy_reg[chk_dst];

    assign wb_en   = wb_en_reg;
    assign wb_addr = wb_addr_reg;
    assign wb_data = wb_data_reg;
    assign sb_busy = busy_reg;
    assign sb_err  = err_reg;

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: arbitration, write stage latency, scoreboard
// set/clear/error behaviour and asynchronous reset.
module tb_wb_sched;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 64;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*5-1:0]    req_addr;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsv_valid;
    logic [4:0]              rsv_addr;
    logic [4:0]              chk_addr1;
    logic [4:0]              chk_addr2;
    logic [4:0]              chk_dst;
    logic                    chk_busy;
    logic                    wb_en;
    logic [4:0]              wb_addr;
    logic [XLEN-1:0]         wb_data;
    logic [31:0]             sb_busy;
    logic                    sb_err;

    int tests = 0;
    int fails = 0;

    wb_sched #(
        .NUM_REQ (NUM_REQ),
        .XLEN    (XLEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_dst   (chk_dst),
        .chk_busy  (chk_busy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .sb_busy   (sb_busy),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        req_addr[i*5 +: 5]       = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    logic [NUM_REQ-1:0] exp_grant [6];
    logic [4:0]         exp_waddr [6];

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;
        chk_dst   = '0;

        // Reset state
        do_reset();
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_sb_busy", {32'd0, sb_busy}, 64'd0);
        check("rst_sb_err", {63'd0, sb_err}, 64'd0);

        // Single load writeback of x5
        set_req(1, 5'd5, 64'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        check("t1_ready", {61'd0, req_ready}, 64'h2);
        tick();
        req_valid = '0;
        check("t1_wb_en", {63'd0, wb_en}, 64'd1);
        check("t1_wb_addr", {59'd0, wb_addr}, 64'd5);
        check("t1_wb_data", wb_data, 64'hDEAD_BEEF);
        tick();
        check("t1_wb_en_drop", {63'd0, wb_en}, 64'd0);
        check("t1_wb_addr_hold", {59'd0, wb_addr}, 64'd5);

        // Three requesters contending for six cycles, from a fresh reset
        do_reset();
`ifdef WB_SCHED_RR_EN
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_waddr = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
`else
        exp_grant = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        exp_waddr = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
`endif
        set_req(0, 5'd1, 64'h11);
        set_req(1, 5'd2, 64'h22);
        set_req(2, 5'd3, 64'h33);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("t2_grant%0d", k), {61'd0, req_ready}, {61'd0, exp_grant[k]});
            tick();
            check($sformatf("t2_wb_addr%0d", k), {59'd0, wb_addr}, {59'd0, exp_waddr[k]});
        end
        req_valid = '0;
        tick();

        // Reserve x7, then ALU writes it back
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk_addr1 = 5'd7;
        #1;
        check("t3_busy_rsv", {63'd0, chk_busy}, 64'd1);
        set_req(0, 5'd7, 64'h77);
        req_valid = 3'b001;
        #1;
        check("t3_ready", {61'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;
        check("t3_wb_en", {63'd0, wb_en}, 64'd1);
        check("t3_busy_wbcyc", {63'd0, chk_busy}, 64'd1);
        check("t3_sb7_wbcyc", {63'd0, sb_busy[7]}, 64'd1);
        tick();
        check("t3_busy_after", {63'd0, chk_busy}, 64'd0);
        check("t3_sb7_after", {63'd0, sb_busy[7]}, 64'd0);
        chk_addr1 = '0;

        // x9: same-edge reserve and clear, then double reservation
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        tick();
        rsv_valid = 1'b0;
        set_req(0, 5'd9, 64'h99);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        check("t4_wb_addr", {59'd0, wb_addr}, 64'd9);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        tick();
        check("t4_sb9_setwins", {63'd0, sb_busy[9]}, 64'd1);
        check("t4_err_clean", {63'd0, sb_err}, 64'd0);
        tick();
        rsv_valid = 1'b0;
        check("t4_err_set", {63'd0, sb_err}, 64'd1);
        check("t4_sb9_still", {63'd0, sb_busy[9]}, 64'd1);
        set_req(0, 5'd9, 64'h9A);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        tick();
        check("t4_sb9_clear", {63'd0, sb_busy[9]}, 64'd0);
        check("t4_err_sticky", {63'd0, sb_err}, 64'd1);

        // Writes and reservations of x0
        set_req(2, 5'd0, 64'h55);
        req_valid = 3'b100;
        #1;
        check("t5_ready", {61'd0, req_ready}, 64'h4);
        tick();
        req_valid = '0;
        check("t5_wb_en_x0", {63'd0, wb_en}, 64'd0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        tick();
        rsv_valid = 1'b0;
        check("t5_sb0", {63'd0, sb_busy[0]}, 64'd0);
        check("t5_sb_all", {32'd0, sb_busy}, 64'd0);

        // Asynchronous reset mid-cycle with a write in flight
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        set_req(0, 5'd3, 64'h1234);
        req_valid = 3'b001;
        tick();
        rsv_valid = 1'b0;
        req_valid = '0;
        check("t6_pre_wb_en", {63'd0, wb_en}, 64'd1);
        check("t6_pre_sb", {32'd0, sb_busy}, 64'h80);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_wb_en", {63'd0, wb_en}, 64'd0);
        check("t6_sb_busy", {32'd0, sb_busy}, 64'd0);
        check("t6_sb_err", {63'd0, sb_err}, 64'd0);
        check("t6_wb_addr", {59'd0, wb_addr}, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
